// File: rtl/mips_lite_mc_control_pkg.sv
`default_nettype none
// ============================================================================
// mips_lite_pkg : shared state, opcode and control encodings for the
//                 MIPS-lite multicycle controller.
// Revision 1.0
// ============================================================================
package mips_lite_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // *_rdy / *_zero fields are qualified by the live mem_ready / zero inputs
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write_rdy;
        logic       pc_en;
        logic       pc_en_rdy;
        logic       pc_en_zero;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       done;
        logic       done_rdy;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read     = 1'b1;
                c.alu_src_b    = SRCB_FOUR;
                c.ir_write_rdy = 1'b1;
                c.pc_en_rdy    = 1'b1;
            end
            S_DECODE: c.alu_src_b = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                c.done_rdy  = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = ALU_SUB;
                c.pc_src     = PC_ALUOUT;
                c.pc_en_zero = 1'b1;
                c.done       = 1'b1;
            end
            S_JUMP: begin
                c.pc_src = PC_JUMP;
                c.pc_en  = 1'b1;
                c.done   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_lite_mc_control_if.sv
`default_nettype none
// ============================================================================
// mips_lite_mc_control_if : controller <-> datapath/memory control bundle.
// Revision 1.0
// ============================================================================
interface mips_lite_mc_control_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output iord, mem_read, mem_write, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, bus_error, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  iord, mem_read, mem_write, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, bus_error, state
    );
endinterface
`default_nettype wire

// File: rtl/mips_lite_mc_control_wait_timer.sv
`default_nettype none
// ============================================================================
// mips_lite_wait_timer : counts consecutive memory wait cycles, flags timeout.
// Revision 1.0
// ============================================================================
module mips_lite_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic hold,
    output logic timeout
);
    logic [4:0] r_count;

    // Fires on the wait cycle whose increment would bring the count to the limit
    assign timeout = hold && (r_count == 5'(WAIT_LIMIT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= 5'd0;
        end else if (hold && !timeout) begin
            r_count <= r_count + 5'd1;
        end else begin
            r_count <= 5'd0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mips_lite_mc_control.sv
`default_nettype none
// ============================================================================
// mips_lite_mc_control : multicycle control FSM for the MIPS-lite datapath.
// Revision 1.0
// ============================================================================
module mips_lite_mc_control
    import mips_lite_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    mips_lite_mc_control_if.master bus
);
    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   r_illegal;
    logic   r_bus_error;
    logic   w_hold;
    logic   w_timeout;
    logic   w_bad_op;

    assign w_hold = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                    && !bus.mem_ready;

    mips_lite_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .hold    (w_hold),
        .timeout (w_timeout)
    );

    always_comb begin
        w_next   = r_state;
        w_bad_op = 1'b0;
        case (r_state)
            S_IDLE:   w_next = (r_illegal || r_bus_error) ? S_IDLE : S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
                      else if (w_timeout) w_next = S_IDLE;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_bad_op = 1'b1;
                        w_next   = S_IDLE;
                    end
                endcase
            end
            S_MEMADR: w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
                      else if (w_timeout) w_next = S_IDLE;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
                      else if (w_timeout) w_next = S_IDLE;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control word is registered for the state being entered
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_ctrl      <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
            if (w_bad_op)  r_illegal   <= 1'b1;
            if (w_timeout) r_bus_error <= 1'b1;
        end
    end

    assign bus.iord       = r_ctrl.iord;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.ir_write   = r_ctrl.ir_write_rdy & bus.mem_ready;
    assign bus.pc_en      = r_ctrl.pc_en | (r_ctrl.pc_en_rdy & bus.mem_ready)
                          | (r_ctrl.pc_en_zero & bus.zero);
    assign bus.pc_src     = r_ctrl.pc_src;
    assign bus.alu_src_a  = r_ctrl.alu_src_a;
    assign bus.alu_src_b  = r_ctrl.alu_src_b;
    assign bus.alu_op     = r_ctrl.alu_op;
    assign bus.reg_dst    = r_ctrl.reg_dst;
    assign bus.mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.instr_done = r_ctrl.done | (r_ctrl.done_rdy & bus.mem_ready);
    assign bus.illegal_op = r_illegal;
    assign bus.bus_error  = r_bus_error;
    assign bus.state      = r_state;
endmodule
`default_nettype wire
